// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master.
// SCL phase states and divisor limits.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW1,
    ST_LOW2,
    ST_WAIT_HIGH,
    ST_HIGH1,
    ST_HIGH2
  } i2c_state_t;

  localparam int I2C_DIV_MIN          = 2;
  localparam int I2C_DEFAULT_DIV_100K = 125;
  localparam int I2C_DEFAULT_DIV_400K = 31;

endpackage

// File: rtl/i2c_sync.sv
// Multi-flop level synchroniser for open-drain bus lines.
// Resets to 1 (idle bus level).
module i2c_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '1;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/i2c_scl_timer.sv
// SCL timing generator: programmable quarter period,
// clock-stretch handling with timeout, phase ticks.
module i2c_scl_timer
  import i2c_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int DEFAULT_DIV = I2C_DEFAULT_DIV_100K,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_MAX = 65535
) (
  input  logic                 ref_clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] div_quarter,
  input  logic                 div_load,
  input  logic                 scl_in,
  output logic                 scl_oe,
  output logic                 tick_fall,
  output logic                 tick_low_mid,
  output logic                 tick_rise,
  output logic                 tick_high_mid,
  output logic                 stretching,
  output logic                 stretch_err,
  output logic                 busy
);

  localparam int WW = $clog2(STRETCH_MAX + 1);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t DIV_RST = cnt_t'(DEFAULT_DIV);
  localparam cnt_t DIV_MIN = cnt_t'(I2C_DIV_MIN);

  i2c_state_t    state;
  i2c_state_t    nxt;
  cnt_t          phase;
  cnt_t          d_act;
  cnt_t          shadow;
  cnt_t          div_sel;
  cnt_t          div_clamp;
  logic [WW-1:0] wcnt;
  logic          scl_s;
  logic          phase_end;
  logic          wait_last;
  logic          timeout;
  logic          enter_low1;

  // The FSM decision register forms the last synchroniser stage.
  i2c_sync #(
    .STAGES(SYNC_STAGES - 1)
  ) u_sync (
    .clk  (ref_clk),
    .rst_n(reset_n),
    .d    (scl_in),
    .q    (scl_s)
  );

  assign phase_end  = (phase == d_act - 1'b1);
  assign wait_last  = (int'(wcnt) >= STRETCH_MAX - 1);
  assign div_sel    = div_load ? div_quarter : shadow;
  assign div_clamp  = (div_sel < DIV_MIN) ? DIV_MIN : div_sel;
  assign enter_low1 = (nxt == ST_LOW1) && (state != ST_LOW1);

  always_comb begin
    nxt     = state;
    timeout = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable) nxt = ST_LOW1;
      end
      ST_LOW1: begin
        if (phase_end) nxt = ST_LOW2;
      end
      ST_LOW2: begin
        if (phase_end) nxt = ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: begin
        if (scl_s) begin
          nxt = ST_HIGH1;
        end else if (wait_last) begin
          nxt     = ST_IDLE;
          timeout = 1'b1;
        end
      end
      ST_HIGH1: begin
        if (phase_end) nxt = ST_HIGH2;
      end
      ST_HIGH2: begin
        if (phase_end) nxt = enable ? ST_LOW1 : ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      phase  <= '0;
      wcnt   <= '0;
      shadow <= DIV_RST;
      d_act  <= DIV_RST;
    end else begin
      state <= nxt;
      phase <= (nxt != state) ? '0 : phase + 1'b1;
      if (state == ST_WAIT_HIGH && nxt == ST_WAIT_HIGH) begin
        if (int'(wcnt) < STRETCH_MAX) wcnt <= wcnt + 1'b1;
      end else begin
        wcnt <= '0;
      end
      if (div_load) shadow <= div_quarter;
      if (enter_low1) d_act <= div_clamp;
    end
  end

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_oe        <= 1'b0;
      tick_fall     <= 1'b0;
      tick_low_mid  <= 1'b0;
      tick_rise     <= 1'b0;
      tick_high_mid <= 1'b0;
      stretching    <= 1'b0;
      stretch_err   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      scl_oe        <= (nxt == ST_LOW1) || (nxt == ST_LOW2);
      busy          <= (nxt != ST_IDLE);
      tick_fall     <= enter_low1;
      tick_low_mid  <= (state == ST_LOW1) && (nxt == ST_LOW2);
      tick_rise     <= (state == ST_WAIT_HIGH) && (nxt == ST_HIGH1);
      tick_high_mid <= (state == ST_HIGH1) && (nxt == ST_HIGH2);
      stretching    <= (state == ST_WAIT_HIGH) &&
                       (nxt == ST_WAIT_HIGH) &&
                       (int'(wcnt) + 1 >= SYNC_STAGES);
      if (timeout) begin
        stretch_err <= 1'b1;
      end else if (div_load) begin
        stretch_err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/i2c_scl_timer.md
# i2c_scl_timer

Parametrised SCL timing generator for the I2C master, successor to the fixed-divisor clock divider. From `ref_clk` (50 MHz) it produces an open-drain SCL drive with a runtime-programmable quarter-period. It honours slave clock stretching, with a timeout, and emits single-cycle phase ticks that the byte/bit engine uses to change SDA and sample SDA.

## Interface
- `CNT_WIDTH`, 16: width of the quarter-period counter and divisor.
- `DEFAULT_DIV`, 125: quarter-period after reset, in `ref_clk` cycles (125 gives 100 kHz at 50 MHz).
- `SYNC_STAGES`, 2: flop stages on `scl_in`; minimum 2.
- `STRETCH_MAX`, 65535: maximum `ref_clk` cycles spent in WAIT_HIGH before a timeout.
- `ref_clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run SCL; sampled at IDLE and at the end of HIGH2.
- `div_quarter`  in  CNT_WIDTH  new quarter-period value.
- `div_load`  in  1  one-cycle strobe; captures `div_quarter` into the shadow register.
- `scl_in`  in  1  raw SCL bus level (asynchronous).
- `scl_oe`  out  1  1 = drive SCL low; 0 = release the line.
- `tick_fall`  out  1  one-cycle pulse: SCL driven low.
- `tick_low_mid`  out  1  one-cycle pulse: SDA change point.
- `tick_rise`  out  1  one-cycle pulse: SCL observed high.
- `tick_high_mid`  out  1  one-cycle pulse: SDA sample point.
- `stretching`  out  1  high while SCL is released but still observed low beyond the sync latency.
- `stretch_err`  out  1  sticky timeout flag; cleared by `div_load` or reset.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOW1, LOW2, WAIT_HIGH, HIGH1, HIGH2.
- IDLE:
  - `scl_oe`=0.
  - If `enable`=1, go to LOW1 and pulse `tick_fall`.
- LOW1 and LOW2:
  - `scl_oe`=1.
  - Each lasts D cycles.
  - LOW1→LOW2 pulses `tick_low_mid`.
  - LOW2→WAIT_HIGH releases SCL.
- WAIT_HIGH:
  - `scl_oe`=0.
  - When synchronised SCL reads 1, go to HIGH1 and pulse `tick_rise`.
  - `stretching`=1 from the (SYNC_STAGES+1)th WAIT_HIGH cycle onward while synchronised SCL reads 0.
  - If the WAIT_HIGH cycle count reaches STRETCH_MAX: set `stretch_err` and go to IDLE. No ticks are issued.
- HIGH1 and HIGH2:
  - `scl_oe`=0.
  - Each lasts D cycles.
  - HIGH1→HIGH2 pulses `tick_high_mid`.
  - At the end of HIGH2: if `enable`=1, go to LOW1 with `tick_fall`; otherwise go to IDLE.
- Deasserting `enable` mid-period does not truncate the period; the current period finishes through HIGH2.
- Divisor handling:
  - D is the active divisor. It is copied from the shadow register only on entry to LOW1, so a change never splits a period.
  - A shadow value of 0 or 1 is clamped to 2.
  - The shadow resets to DEFAULT_DIV.
- The phase counter runs 0..D-1 and is cleared on every state change.
- The WAIT_HIGH counter saturates at STRETCH_MAX.
- Simultaneous `div_load` and timeout: `stretch_err` ends the cycle at 1. The set takes priority; the clear applies on the next `div_load`.
- Reset values: state IDLE, `scl_oe`=0, all ticks 0, `stretching`=0, `stretch_err`=0, `busy`=0, synchroniser flops 1.

## Timing
- All outputs are registered. Ticks assert in the first cycle of the new state, for exactly one cycle.
- `enable` asserted in cycle n while IDLE gives `scl_oe`=1 and `tick_fall`=1 in cycle n+1.
- With no stretching, WAIT_HIGH lasts SYNC_STAGES cycles.
- Period without stretching, fall to fall, is 4·D + SYNC_STAGES. With D=125 and SYNC_STAGES=2 this is 502 cycles.
- Stretching of S extra cycles lengthens only the low portion seen on the bus. HIGH1+HIGH2 always equal 2·D.
- `tick_low_mid` follows `tick_fall` by D cycles.
- `tick_high_mid` follows `tick_rise` by D cycles.
- A `div_load` in any cycle up to and including the cycle before LOW1 entry takes effect in that LOW1.
- Asserting `reset_n` low mid-operation releases SCL immediately (asynchronously) and drops all ticks.

## Structure
- Package `i2c_pkg`:
  - state enumeration;
  - `I2C_DIV_MIN`=2;
  - `I2C_DEFAULT_DIV_100K`=125;
  - `I2C_DEFAULT_DIV_400K`=31.
- Sub-module `i2c_sync`: SYNC_STAGES-deep synchroniser with reset value 1. Reused later for SDA.
- Top: FSM, phase counter, WAIT_HIGH counter, shadow and active divisor registers.

## Test plan
- Reset, then `enable`=1 held, bench `scl_in`=~`scl_oe`:
  - `tick_fall` one cycle after `enable`;
  - fall-to-fall period of 502 cycles;
  - `tick_low_mid` 125 cycles after `tick_fall`;
  - `tick_high_mid` 125 cycles after `tick_rise`.
- `div_quarter`=31 loaded mid-period:
  - the current period stays at 502 cycles;
  - the next period is 126 cycles (4·31+2).
- Bench holds `scl_in` low 40 extra cycles after release:
  - `stretching` high for 40 cycles;
  - period becomes 542 cycles;
  - high time stays 250 cycles.
- `scl_in` stuck low with STRETCH_MAX=100:
  - `stretch_err`=1 after 100 WAIT_HIGH cycles;
  - state IDLE, `busy`=0, no `tick_rise`;
  - a later `div_load` clears `stretch_err`.
- `enable` dropped during LOW2: current period completes, then IDLE with `scl_oe`=0. A `div_quarter` of 0 loaded and run gives a period of 10 cycles.
- `reset_n` low during HIGH1: `scl_oe`=0 and ticks 0 immediately; after release, the state is IDLE with D=DEFAULT_DIV.
